// File: rtl/instr_decode_issue_if.sv
// Handshake and decoded-bundle bus between the instruction source, the
// decode/issue unit and the ALU_Control consumer.
interface instr_decode_issue_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [31:0]      instr;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic [2:0]       alu_op;
    logic [9:0]       function_code;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
    logic             mem_to_reg;
    logic             branch;
    logic [1:0]       branch_type;
    logic             illegal;
    logic             err_clr;
    logic             halted;
    logic [CNT_W-1:0] issue_count;

    modport master (
        output in_valid, instr, out_ready, err_clr,
        input  in_ready, out_valid, alu_op, function_code, reg_write, mem_read,
               mem_write, alu_src, mem_to_reg, branch, branch_type, illegal,
               halted, issue_count
    );

    modport slave (
        input  in_valid, instr, out_ready, err_clr,
        output in_ready, out_valid, alu_op, function_code, reg_write, mem_read,
               mem_write, alu_src, mem_to_reg, branch, branch_type, illegal,
               halted, issue_count
    );
endinterface

// File: rtl/instr_decode_issue.sv
// Registered instruction decode/issue unit feeding ALU_Control: captures an
// instruction, decodes it in one cycle and holds the bundle until consumed.
module instr_decode_issue #(
    parameter int CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_decode_issue_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_ERROR  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]       state;
    logic [5:0]       opcode_q;
    logic [9:0]       func_q;
    logic [CNT_W-1:0] cnt;

    logic [2:0] alu_op_q;
    logic [9:0] function_code_q;
    logic       reg_write_q, mem_read_q, mem_write_q, alu_src_q, mem_to_reg_q, branch_q;
    logic [1:0] branch_type_q;
    logic       illegal_q, halted_q;

    logic [2:0] d_alu_op;
    logic [9:0] d_function_code;
    logic       d_reg_write, d_mem_read, d_mem_write, d_alu_src, d_mem_to_reg, d_branch;
    logic [1:0] d_branch_type;
    logic       d_illegal, d_halt;

    // Only the opcode and function fields are ever decoded.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[25:10];

    always_comb begin
        d_alu_op        = '0;
        d_function_code = '0;
        d_reg_write     = 1'b0;
        d_mem_read      = 1'b0;
        d_mem_write     = 1'b0;
        d_alu_src       = 1'b0;
        d_mem_to_reg    = 1'b0;
        d_branch        = 1'b0;
        d_branch_type   = '0;
        d_illegal       = 1'b0;
        d_halt          = 1'b0;
        case (opcode_q)
            6'b000000: begin
                d_alu_op        = 3'b001;
                d_reg_write     = 1'b1;
                d_function_code = func_q;
                d_illegal       = (func_q > 10'd3);
            end
            6'b000001: begin
                d_alu_op        = 3'b010;
                d_reg_write     = 1'b1;
                d_alu_src       = 1'b1;
                d_function_code = func_q;
                d_illegal       = (func_q > 10'd2);
            end
            6'b000010: begin
                d_alu_op        = 3'b011;
                d_reg_write     = 1'b1;
                d_function_code = func_q;
                d_illegal       = (func_q > 10'd2);
            end
            6'b000011: begin
                d_alu_op    = 3'b100;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            6'b000100: begin
                d_alu_op    = 3'b101;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            6'b000101: begin
                d_alu_op     = 3'b100;
                d_reg_write  = 1'b1;
                d_mem_read   = 1'b1;
                d_alu_src    = 1'b1;
                d_mem_to_reg = 1'b1;
            end
            6'b000110: begin
                d_alu_op    = 3'b100;
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            6'b000111: begin
                d_alu_op      = 3'b110;
                d_branch      = 1'b1;
                d_branch_type = 2'b11;
            end
            6'b001000: begin
                d_alu_op      = 3'b110;
                d_branch      = 1'b1;
                d_branch_type = 2'b01;
            end
            6'b001001: begin
                d_alu_op      = 3'b110;
                d_branch      = 1'b1;
                d_branch_type = 2'b10;
            end
            6'b001010: begin
                d_branch      = 1'b1;
                d_branch_type = 2'b00;
            end
            6'b111111: d_halt = 1'b1;
            default:   d_illegal = 1'b1;
        endcase
        // An illegal encoding must present an all-zero bundle downstream.
        if (d_illegal) begin
            d_alu_op        = '0;
            d_function_code = '0;
            d_reg_write     = 1'b0;
            d_mem_read      = 1'b0;
            d_mem_write     = 1'b0;
            d_alu_src       = 1'b0;
            d_mem_to_reg    = 1'b0;
            d_branch        = 1'b0;
            d_branch_type   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            opcode_q        <= '0;
            func_q          <= '0;
            cnt             <= '0;
            alu_op_q        <= '0;
            function_code_q <= '0;
            reg_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            alu_src_q       <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            branch_q        <= 1'b0;
            branch_type_q   <= '0;
            illegal_q       <= 1'b0;
            halted_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        opcode_q <= bus.instr[31:26];
                        func_q   <= bus.instr[9:0];
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_op_q        <= d_alu_op;
                    function_code_q <= d_function_code;
                    reg_write_q     <= d_reg_write;
                    mem_read_q      <= d_mem_read;
                    mem_write_q     <= d_mem_write;
                    alu_src_q       <= d_alu_src;
                    mem_to_reg_q    <= d_mem_to_reg;
                    branch_q        <= d_branch;
                    branch_type_q   <= d_branch_type;
                    if (d_illegal) begin
                        illegal_q <= 1'b1;
                        state     <= S_ERROR;
                    end else if (d_halt) begin
                        halted_q <= 1'b1;
                        state    <= S_HALTED;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.out_ready) begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (bus.err_clr) begin
                        illegal_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == S_IDLE);
    assign bus.out_valid     = (state == S_ISSUE);
    assign bus.alu_op        = alu_op_q;
    assign bus.function_code = function_code_q;
    assign bus.reg_write     = reg_write_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.alu_src       = alu_src_q;
    assign bus.mem_to_reg    = mem_to_reg_q;
    assign bus.branch        = branch_q;
    assign bus.branch_type   = branch_type_q;
    assign bus.illegal       = illegal_q;
    assign bus.halted        = halted_q;
    assign bus.issue_count   = cnt;
endmodule

// File: tb/tb_instr_decode_issue.sv
// Self-checking bench for instr_decode_issue: a default-width unit and a
// 4-bit-counter unit run the same stimulus against a table-driven decode model.
module tb_instr_decode_issue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_decode_issue_if #(.CNT_W(16)) bus ();
    instr_decode_issue_if #(.CNT_W(4))  bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.instr     = bus.instr;
    assign bus4.out_ready = bus.out_ready;
    assign bus4.err_clr   = bus.err_clr;

    instr_decode_issue #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    instr_decode_issue #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int errors = 0;
    int checks = 0;
    int unsigned model_cnt = 0;

    typedef struct packed {
        logic        legal;
        logic        halt;
        logic [20:0] b;
    } ref_t;

    // Bundle layout: alu_op, function_code, rw, mr, mw, alu_src, mem_to_reg, branch, branch_type
    logic [20:0] obs;
    assign obs = {bus.alu_op, bus.function_code, bus.reg_write, bus.mem_read, bus.mem_write,
                  bus.alu_src, bus.mem_to_reg, bus.branch, bus.branch_type};

    function automatic ref_t ref_decode(input logic [31:0] ins);
        ref_t r;
        int op, fn;
        logic [2:0] alu;
        logic [9:0] func;
        logic [5:0] ctl;
        logic [1:0] bt;
        op = int'(ins[31:26]);
        fn = int'(ins[9:0]);
        r.legal = 1'b1; r.halt = 1'b0;
        alu = '0; func = '0; ctl = '0; bt = '0;
        case (op)
            0:  begin alu = 3'd1; ctl = 6'b100000; func = ins[9:0]; r.legal = (fn <= 3); end
            1:  begin alu = 3'd2; ctl = 6'b100100; func = ins[9:0]; r.legal = (fn <= 2); end
            2:  begin alu = 3'd3; ctl = 6'b100000; func = ins[9:0]; r.legal = (fn <= 2); end
            3:  begin alu = 3'd4; ctl = 6'b100100; end
            4:  begin alu = 3'd5; ctl = 6'b100100; end
            5:  begin alu = 3'd4; ctl = 6'b110110; end
            6:  begin alu = 3'd4; ctl = 6'b001100; end
            7:  begin alu = 3'd6; ctl = 6'b000001; bt = 2'd3; end
            8:  begin alu = 3'd6; ctl = 6'b000001; bt = 2'd1; end
            9:  begin alu = 3'd6; ctl = 6'b000001; bt = 2'd2; end
            10: begin alu = 3'd0; ctl = 6'b000001; bt = 2'd0; end
            63: r.halt = 1'b1;
            default: r.legal = 1'b0;
        endcase
        if (!r.legal || r.halt) begin
            alu = '0; func = '0; ctl = '0; bt = '0;
        end
        r.b = {alu, func, ctl, bt};
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
    endtask

    task automatic do_txn(input logic [31:0] ins, input int stall);
        ref_t r;
        r = ref_decode(ins);
        @(negedge clk);
        bus.instr = ins; bus.in_valid = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready instr=%h got %b exp 1", ins, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.instr = $urandom;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            errors++; $display("FAIL decode_hs instr=%h got %b exp 00", ins, {bus.in_ready, bus.out_valid});
        end
        @(negedge clk);
        if (r.halt) begin
            checks++;
            if ({bus.halted, bus.in_ready, bus.out_valid} !== 3'b100) begin
                errors++; $display("FAIL halt_state got %b exp 100", {bus.halted, bus.in_ready, bus.out_valid});
            end
        end else if (!r.legal) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({bus.illegal, bus.out_valid, bus.in_ready, obs} !== {3'b100, 21'd0}) begin
                    errors++; $display("FAIL illegal_state instr=%h got %b/%h exp 100/0", ins,
                                       {bus.illegal, bus.out_valid, bus.in_ready}, obs);
                end
                @(negedge clk);
            end
            bus.err_clr = 1'b1;
            @(negedge clk);
            bus.err_clr = 1'b0;
            checks++;
            if ({bus.illegal, bus.in_ready, bus.out_valid} !== 3'b010) begin
                errors++; $display("FAIL err_clr got %b exp 010", {bus.illegal, bus.in_ready, bus.out_valid});
            end
        end else begin
            checks++;
            if ({bus.out_valid, bus.illegal, obs} !== {2'b10, r.b}) begin
                errors++; $display("FAIL issue_bundle instr=%h got %b/%h exp 10/%h", ins,
                                   {bus.out_valid, bus.illegal}, obs, r.b);
            end
            for (int i = 0; i < stall; i++) begin
                bus.err_clr = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if ({bus.out_valid, bus.in_ready, obs} !== {2'b10, r.b} ||
                    bus.issue_count !== 16'(model_cnt)) begin
                    errors++; $display("FAIL stall_hold instr=%h cyc=%0d got %b/%h/%0d exp 10/%h/%0d", ins, i,
                                       {bus.out_valid, bus.in_ready}, obs, bus.issue_count, r.b, model_cnt);
                end
            end
            bus.err_clr = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            model_cnt++;
            checks++;
            if ({bus.out_valid, bus.in_ready, obs} !== {2'b01, r.b} ||
                bus.issue_count !== 16'(model_cnt) || bus4.issue_count !== 4'(model_cnt)) begin
                errors++; $display("FAIL consume instr=%h got %b/%h/%0d/%0d exp 01/%h/%0d/%0d", ins,
                                   {bus.out_valid, bus.in_ready}, obs, bus.issue_count, bus4.issue_count,
                                   r.b, model_cnt, model_cnt % 16);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
        #12;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.illegal, bus.halted, obs} !== {4'b1000, 21'd0} ||
            bus.issue_count !== 16'd0 || bus4.issue_count !== 4'd0) begin
            errors++; $display("FAIL reset_state got %b/%h/%0d exp 1000/0/0",
                               {bus.in_ready, bus.out_valid, bus.illegal, bus.halted}, obs, bus.issue_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
    endtask

    task automatic test_add();
        do_txn(32'h0000_0000, 0);
    endtask

    task automatic test_opcode_sweep();
        logic [31:0] list [0:10];
        list = '{32'h1400_0000, 32'h1800_0000, 32'h1C00_0123, 32'h2000_0000, 32'h2400_03FF,
                 32'h2800_0055, 32'h0C00_0201, 32'h1000_0007, 32'h0400_0002, 32'h0000_0003,
                 32'h0800_0001};
        foreach (list[i]) do_txn(list[i], 1);
    endtask

    task automatic test_backpressure();
        do_txn(32'h0800_0002, 5);
    endtask

    task automatic test_illegal();
        do_txn(32'h0000_0004, 0);
        do_txn(32'h4000_0000, 0);
        do_txn(32'h0400_0003, 0);
        do_txn(32'h0000_0001, 0);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            ins[31:26] = 6'($urandom_range(0, 14));
            if ($urandom_range(0, 1) == 1) ins[9:0] = 10'($urandom_range(0, 5));
            do_txn(ins, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        ref_t r;
        logic [31:0] ins;
        ins = {6'b000011, 26'($urandom)};
        r = ref_decode(ins);
        @(negedge clk);
        bus.instr = ins; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 9) bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== ((k % 3) == 2) || (bus.out_valid === 1'b1 && obs !== r.b)) begin
                errors++; $display("FAIL back_to_back cyc=%0d got %b/%h exp %b/%h", k, bus.out_valid, obs,
                                   ((k % 3) == 2), r.b);
            end
            if ((k % 3) == 0) model_cnt++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.issue_count !== 16'(model_cnt) || bus4.issue_count !== 4'(model_cnt)) begin
            errors++; $display("FAIL b2b_count got %0d/%0d exp %0d", bus.issue_count, bus4.issue_count, model_cnt);
        end
    endtask

    task automatic test_halt_reset();
        do_txn(32'hFC00_0000, 0);
        bus.in_valid = 1'b1; bus.instr = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            bus.err_clr = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({bus.halted, bus.in_ready, bus.out_valid} !== 3'b100 || bus.issue_count !== 16'(model_cnt)) begin
                errors++; $display("FAIL halt_sticky cyc=%0d got %b/%0d exp 100/%0d", i,
                                   {bus.halted, bus.in_ready, bus.out_valid}, bus.issue_count, model_cnt);
            end
        end
        bus.in_valid = 1'b0; bus.err_clr = 1'b0;
        do_reset();
        @(negedge clk);
        bus.instr = 32'h1400_0000; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_issue got %b exp 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        model_cnt = 0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.illegal, bus.halted, obs} !== {4'b1000, 21'd0} ||
            bus.issue_count !== 16'd0) begin
            errors++; $display("FAIL async_reset got %b/%h/%0d exp 1000/0/0",
                               {bus.in_ready, bus.out_valid, bus.illegal, bus.halted}, obs, bus.issue_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) do_txn(32'h0000_0000, 0);
        checks++;
        if (bus4.issue_count !== 4'd1 || bus.issue_count !== 16'd17) begin
            errors++; $display("FAIL counter_wrap got %0d/%0d exp 1/17", bus4.issue_count, bus.issue_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_opcode_sweep();
        test_backpressure();
        test_illegal();
        test_random();
        test_back_to_back();
        test_halt_reset();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
